// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
//   Shares one byte-level I2C master engine between NREQ requesters.
//   The arbiter picks a winner round-robin and latches that port's address,
//   direction and write byte. It then issues one start pulse to the engine
//   and waits for the engine's done. Read data and NACK status are returned
//   to the winner together with a one-cycle req_done pulse.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     req/req_addr/req_rw/     per-port request level and transaction fields
//     req_wdata                (port i at [i*AW +: AW] / [i*8 +: 8])
//     gnt                      one-hot grant, zero when idle
//     req_done                 one-cycle completion pulse to the winner
//     rsp_rdata/rsp_nack/      response fields, valid with req_done, then held
//     rsp_timeout
//     m_start/m_addr/m_rw/     engine command side (start is a one-cycle pulse)
//     m_wdata/m_abort
//     m_busy/m_done/m_rdata/   engine status side
//     m_nack
//
//   Optional feature: define I2C_ARB_TIMEOUT_EN to abort a transaction when
//   the engine stays silent for TO_CYC cycles in WAIT.
module i2c_req_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 7,
  parameter int TO_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   req_done,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_nack,
  output logic              rsp_timeout,
  output logic              m_start,
  output logic [AW-1:0]     m_addr,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  output logic              m_abort,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [7:0]        m_rdata,
  input  logic              m_nack
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TO_CYC < 2 || TO_CYC > 65536) begin : g_param_chk
    $error("i2c_req_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [7:0]      rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rw_q, rw_d, nack_q, nack_d, start_q, start_d;
  logic [PW-1:0]   win;
  logic            any;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d, tout_q, tout_d;
`endif

  // Round-robin pick: first requester after the last winner, wrapping.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[(int'(ptr_q) + i) % NREQ]) begin
        any = 1'b1;
        win = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    tout_d  = tout_q;
`endif
    case (state_q)
      S_IDLE: if (any) begin
        own_d      = win;
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        addr_d     = req_addr[win*AW +: AW];
        rw_d       = req_rw[win];
        wdata_d    = req_wdata[win*8 +: 8];
        state_d    = S_ISSUE;
      end
      S_ISSUE: if (!m_busy) begin
        start_d = 1'b1;
        state_d = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // m_done has priority over a timeout landing in the same cycle.
        if (m_done) begin
          done_d[own_q] = 1'b1;
          gnt_d         = '0;
          rdata_d       = m_rdata;
          nack_d        = m_nack;
          state_d       = S_RESP;
`ifdef I2C_ARB_TIMEOUT_EN
          tout_d        = 1'b0;
        end else if (cnt_q == 16'(TO_CYC - 1)) begin
          done_d[own_q] = 1'b1;
          gnt_d         = '0;
          rdata_d       = 8'h00;
          nack_d        = 1'b1;
          tout_d        = 1'b1;
          abort_d       = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      S_RESP: begin
        ptr_d   = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      own_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      abort_q <= 1'b0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign req_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;
  assign m_start   = start_q;
  assign m_addr    = addr_q;
  assign m_rw      = rw_q;
  assign m_wdata   = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign m_abort     = abort_q;
  assign rsp_timeout = tout_q;
`else
  assign m_abort     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
`timescale 1ns/1ps
module tb_i2c_req_arbiter;
  localparam int NREQ = 4, AW = 7, TO_CYC = 16;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]    req = '0, req_rw = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*8-1:0]  req_wdata = '0;
  logic m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [7:0] m_rdata = '0;
  logic [NREQ-1:0] gnt, req_done;
  logic [7:0] rsp_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic rsp_nack, rsp_timeout, m_start, m_rw, m_abort;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NREQ(NREQ), .AW(AW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .req_done(req_done), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .m_start(m_start),
    .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata), .m_abort(m_abort),
    .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the engine, whether the start has
  // gone out, and whether the response cycle is showing.
  int own, last, wcnt;
  bit started, resp;
  logic [NREQ-1:0] e_gnt, e_done;
  logic [7:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;
  logic e_rw, e_start, e_nack, e_to, e_abort;

  task automatic finish_txn(input logic [7:0] rd, input logic nk, input logic to);
    e_done = '0; e_done[own] = 1'b1;
    e_gnt = '0; e_rdata = rd; e_nack = nk; e_to = to; resp = 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own = -1; last = NREQ - 1; started = 0; resp = 0; wcnt = 0;
      e_gnt = '0; e_done = '0; e_rdata = '0; e_wdata = '0; e_addr = '0;
      e_rw = 0; e_start = 0; e_nack = 0; e_to = 0; e_abort = 0;
    end else begin
      e_start = 0; e_done = '0; e_abort = 0;
      if (resp) begin
        resp = 0; last = own; own = -1;
      end else if (own < 0) begin
        for (int i = 1; i <= NREQ; i++)
          if (own < 0 && req[(last + i) % NREQ]) own = (last + i) % NREQ;
        if (own >= 0) begin
          e_gnt = '0; e_gnt[own] = 1'b1;
          e_addr = req_addr[own*AW +: AW];
          e_rw = req_rw[own];
          e_wdata = req_wdata[own*8 +: 8];
          started = 0;
        end
      end else if (!started) begin
        if (!m_busy) begin e_start = 1; started = 1; wcnt = 0; end
      end else begin
        if (m_done) finish_txn(m_rdata, m_nack, 1'b0);
        else if (TO_EN && wcnt == TO_CYC - 1) begin
          finish_txn(8'h00, 1'b1, 1'b1); e_abort = 1;
        end else wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt", gnt, e_gnt);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("req_done", req_done, e_done);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_nack", rsp_nack, e_nack);
    chk("rsp_timeout", rsp_timeout, e_to);
    chk("m_start", m_start, e_start);
    chk("m_addr", m_addr, e_addr);
    chk("m_rw", m_rw, e_rw);
    chk("m_wdata", m_wdata, e_wdata);
    chk("m_abort", m_abort, e_abort);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; req = '0; m_done = 0; m_busy = 0; m_nack = 0;
    tick();
    chk("rst_gnt", gnt, 0); chk("rst_done", req_done, 0);
    chk("rst_start", m_start, 0); chk("rst_addr", m_addr, 0);
    chk("rst_rdata", rsp_rdata, 0); chk("rst_abort", m_abort, 0);
    rst = 0;
    tick();
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!m_start && n < 20) begin tick(); n++; end
    chk({nm, "_start_seen"}, m_start, 1);
  endtask

  task automatic engine_done(input logic [7:0] rd, input logic nk);
    m_done = 1; m_rdata = rd; m_nack = nk;
    tick();
    m_done = 0; m_nack = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    do_reset();

    // Single write to port 0.
    req = 4'b0001; req_addr[0 +: AW] = 7'h50; req_rw[0] = 0; req_wdata[0 +: 8] = 8'hA5;
    tick();
    chk("t1_gnt", gnt, 4'b0001); chk("t1_addr", m_addr, 7'h50);
    chk("t1_wdata", m_wdata, 8'hA5); chk("t1_nostart", m_start, 0);
    tick();
    chk("t1_start", m_start, 1);
    tick();
    chk("t1_start_once", m_start, 0);
    repeat (17) tick();
    engine_done(8'h00, 1'b0);
    chk("t1_done", req_done, 4'b0001); chk("t1_gnt_off", gnt, 0); chk("t1_nack", rsp_nack, 0);
    req = '0;
    tick();
    chk("t1_done_pulse", req_done, 0);

    // Read on port 2.
    req = 4'b0100; req_rw[2] = 1; req_addr[2*AW +: AW] = 7'h21;
    tick();
    chk("t2_gnt", gnt, 4'b0100); chk("t2_rw", m_rw, 1);
    wait_start("t2");
    engine_done(8'h3C, 1'b0);
    chk("t2_done", req_done, 4'b0100); chk("t2_rdata", rsp_rdata, 8'h3C);
    req = '0;
    tick();
    chk("t2_rdata_held", rsp_rdata, 8'h3C);

    // Round-robin with all ports held.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      while (gnt == 0 && n < 20) begin tick(); n++; end
      chk("rr_grant", gnt, 32'(1) << (k % 4));
      wait_start("rr");
      engine_done(8'(k), 1'b0);
      chk("rr_done", req_done, 32'(1) << (k % 4));
      tick();
    end
    req = '0;
    tick(); tick();

    // Busy hold.
    do_reset();
    m_busy = 1; req = 4'b0010;
    tick();
    chk("t4_gnt", gnt, 4'b0010);
    for (int i = 0; i < 10; i++) begin tick(); chk("t4_hold", m_start, 0); end
    m_busy = 0;
    tick();
    chk("t4_start", m_start, 1);
    tick();
    chk("t4_start_once", m_start, 0);
    engine_done(8'h11, 1'b0);
    chk("t4_done", req_done, 4'b0010);
    req = '0;
    tick();

    // NACK, then reset in WAIT.
    req = 4'b1000;
    tick();
    chk("t5_gnt", gnt, 4'b1000);
    wait_start("t5");
    engine_done(8'h77, 1'b1);
    chk("t5_done", req_done, 4'b1000); chk("t5_nack", rsp_nack, 1);
    req = '0;
    tick();
    req = 4'b0100;
    tick();
    wait_start("t5b");
    tick();
    rst = 1; #1;
    chk("t5_rst_gnt", gnt, 0); chk("t5_rst_start", m_start, 0);
    req = 4'b1111;
    tick();
    rst = 0;
    tick();
    chk("t5_after_rst", gnt, 4'b0001);
    wait_start("t5c");
    engine_done(8'h00, 1'b0);
    req = '0;
    tick();

`ifdef I2C_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    chk("t6_start", m_start, 1);
    for (int i = 0; i < 15; i++) begin tick(); chk("t6_no_abort", m_abort, 0); end
    tick();
    chk("t6_abort", m_abort, 1); chk("t6_done", req_done, 4'b0001);
    chk("t6_timeout", rsp_timeout, 1); chk("t6_nack", rsp_nack, 1);
    chk("t6_rdata", rsp_rdata, 0);
    req = '0;
    tick();
    chk("t6_abort_pulse", m_abort, 0);
`endif

    // Randomized traffic against the reference.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (req_done[i] || $urandom_range(0, 31) == 0) req[i] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1;
          req_addr[i*AW +: AW] = AW'($urandom);
          req_rw[i] = 1'($urandom);
          req_wdata[i*8 +: 8] = 8'($urandom);
        end
        if ($urandom_range(0, 15) == 0) req_wdata[i*8 +: 8] = 8'($urandom);
      end
      m_busy  = ($urandom_range(0, 3) == 0);
      m_done  = ($urandom_range(0, 5) == 0);
      m_rdata = 8'($urandom);
      m_nack  = 1'($urandom);
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; m_done = 0; req = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
